// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, PENDING/ENABLE/MODE/STATUS registers, CPU irq vector.
// Optional per-source polarity register when IRQ_CTRL_POLARITY_EN is defined.
module irq_ctrl #(
  parameter int NSRC     = 8,
  parameter int IRQ_BASE = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  output logic            ready,
  input  logic [3:0]      wstrb,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NSRC-1:0] src,
  output logic [31:0]     irq
);

  // Bus: a request is accepted on an edge where valid=1 and ready=0; ready
  // pulses for one cycle afterwards, carrying rdata (0 outside the pulse).
  logic            ready_q;
  logic [31:0]     rdata_q;
  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] src_eff;
  logic [NSRC-1:0] bmask, wbits, clr;
  logic [31:0]     rd_val;
  logic [63:0]     irq_wide;
  logic [2:0]      idx;
  logic            accept, wr;

  assign idx    = addr[4:2];
  assign accept = valid & ~ready_q;
  assign wr     = accept & (|wstrb);

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NSRC; i++) bmask[i] = wstrb[i/8];
  end
  assign wbits = wdata[NSRC-1:0] & bmask;

`ifdef IRQ_CTRL_POLARITY_EN
  logic [NSRC-1:0] pol_q;
  assign src_eff = src ^ pol_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pol_q <= '0;
    else if (wr && idx == 3'd4) pol_q <= (pol_q & ~bmask) | wbits;
  end
`else
  assign src_eff = src;
`endif

  // Edge sources hold until cleared; a same-cycle rise beats the clear.
  always_comb begin
    clr    = (wr && idx == 3'd0) ? wbits : '0;
    pend_d = (mode_q & ((s2_q & ~s3_q) | (pend_q & ~clr))) | (~mode_q & s2_q);
    en_d   = (wr && idx == 3'd1) ? ((en_q & ~bmask) | wbits) : en_q;
    mode_d = (wr && idx == 3'd2) ? ((mode_q & ~bmask) | wbits) : mode_q;
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0: rd_val = 32'(pend_q);
      3'd1: rd_val = 32'(en_q);
      3'd2: rd_val = 32'(mode_q);
      3'd3: rd_val = 32'(pend_q & en_q);
`ifdef IRQ_CTRL_POLARITY_EN
      3'd4: rd_val = 32'(pol_q);
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      s1_q    <= src_eff;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      ready_q <= accept;
      rdata_q <= (accept && wstrb == 4'd0) ? rd_val : 32'd0;
    end
  end

  assign irq_wide = 64'(pend_q & en_q) << IRQ_BASE;
  assign irq      = irq_wide[31:0];
  assign ready    = ready_q;
  assign rdata    = rdata_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, addr[31:5], addr[1:0], wdata, irq_wide[63:32]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, directed corner sequences,
// then randomized traffic against a history-based reference model.
module tb_irq_ctrl;
  localparam int NSRC     = 8;
  localparam int IRQ_BASE = 5;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            valid = 1'b0;
  logic            ready;
  logic [3:0]      wstrb = '0;
  logic [31:0]     addr  = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic [NSRC-1:0] src   = '0;
  logic [31:0]     irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(NSRC), .IRQ_BASE(IRQ_BASE)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .src(src), .irq(irq)
  );

  // Reference model: registers plus a history of the last three sampled sources.
  logic [NSRC-1:0] m_pend, m_en, m_mode, m_pol;
  logic            m_ready;
  logic [31:0]     m_rdata;
  logic [NSRC-1:0] hist[$];

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '0; m_pol = '0;
    m_ready = 1'b0; m_rdata = '0;
    hist = '{NSRC'(0), NSRC'(0), NSRC'(0)};
  endtask

  function automatic logic [31:0] m_read(logic [2:0] i);
    case (i)
      3'd0: return 32'(m_pend);
      3'd1: return 32'(m_en);
      3'd2: return 32'(m_mode);
      3'd3: return 32'(m_pend & m_en);
      3'd4: return 32'(m_pol);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [NSRC-1:0] s2, s3, bm, wv, clr, p;
    logic [2:0] i3;
    logic acc, wr;
    logic [31:0] rd;
    s2  = hist[1];
    s3  = hist[0];
    acc = valid && !m_ready;
    wr  = acc && (wstrb != 4'd0);
    i3  = addr[4:2];
    for (int i = 0; i < NSRC; i++) bm[i] = wstrb[i/8];
    wv  = wdata[NSRC-1:0] & bm;
    rd  = (acc && wstrb == 4'd0) ? m_read(i3) : 32'd0;
    clr = (wr && i3 == 3'd0) ? wv : '0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_mode[i]) p[i] = (s2[i] && !s3[i]) || (m_pend[i] && !clr[i]);
      else           p[i] = s2[i];
    end
    hist.push_back(src ^ m_pol);
    void'(hist.pop_front());
    m_pend = p;
    if (wr && i3 == 3'd1) m_en   = (m_en & ~bm) | wv;
    if (wr && i3 == 3'd2) m_mode = (m_mode & ~bm) | wv;
`ifdef IRQ_CTRL_POLARITY_EN
    if (wr && i3 == 3'd4) m_pol  = (m_pol & ~bm) | wv;
`endif
    m_ready = acc;
    m_rdata = rd;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("irq", irq, 32'(m_pend & m_en) << IRQ_BASE);
    check("ready", 32'(ready), 32'(m_ready));
    check("rdata", rdata, m_rdata);
  endtask

  task automatic bus(input logic [2:0] i3, input logic [3:0] ws, input logic [31:0] wd,
                     output logic [31:0] rd);
    valid = 1'b1; addr = {27'd0, i3, 2'd0}; wstrb = ws; wdata = wd;
    tick();
    rd = rdata;
    valid = 1'b0; wstrb = '0;
    tick();
  endtask

  task automatic bus_wr(input logic [2:0] i3, input logic [3:0] ws, input logic [31:0] wd);
    logic [31:0] d;
    bus(i3, ws, wd, d);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[12];

  initial begin
    logic [31:0] d;
    logic [2:0]  ri;
    logic [3:0]  rws;

    vt[0]  = '{3'd1, 4'hF, 32'hFFFF_FFFF, 32'h0000_00FF};
    vt[1]  = '{3'd1, 4'h2, 32'h0000_0000, 32'h0000_00FF};
    vt[2]  = '{3'd1, 4'h1, 32'h0000_00A5, 32'h0000_00A5};
    vt[3]  = '{3'd1, 4'hE, 32'hFFFF_FF00, 32'h0000_00A5};
    vt[4]  = '{3'd2, 4'h1, 32'h0000_003C, 32'h0000_003C};
    vt[5]  = '{3'd2, 4'h1, 32'h0000_0000, 32'h0000_0000};
    vt[6]  = '{3'd5, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[7]  = '{3'd6, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[8]  = '{3'd7, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[9]  = '{3'd3, 4'hF, 32'h0000_00FF, 32'h0000_0000};
    vt[10] = '{3'd0, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[11] = '{3'd1, 4'h1, 32'h0000_0000, 32'h0000_0000};

    // Reset and reset values
    model_reset();
    repeat (3) @(posedge clk);
    release_reset();
    check("rst_irq", irq, 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus(3'(i), 4'd0, 32'd0, d);
      check("rst_read", d, 32'd0);
    end

    // Register table: write, then read back
    foreach (vt[k]) begin
      bus_wr(vt[k].idx, vt[k].ws, vt[k].wd);
      bus(vt[k].idx, 4'd0, 32'd0, d);
      check($sformatf("table_%0d", k), d, vt[k].exp);
    end

    // Edge mode: latch, hold after src falls, W1C clear
    bus_wr(3'd1, 4'h1, 32'h1);
    bus_wr(3'd2, 4'h1, 32'h1);
    src[0] = 1'b1;
    tick(); tick();
    check("edge_early", 32'(irq[5]), 32'd0);
    tick();
    check("edge_irq", 32'(irq[5]), 32'd1);
    src[0] = 1'b0;
    repeat (4) tick();
    check("edge_hold", 32'(irq[5]), 32'd1);
    bus_wr(3'd0, 4'h1, 32'h1);
    check("edge_clr", 32'(irq[5]), 32'd0);

    // Level mode: W1C ignored, follows src with pipeline delay
    bus_wr(3'd1, 4'h1, 32'h4);
    bus_wr(3'd2, 4'h1, 32'h0);
    src[2] = 1'b1;
    repeat (3) tick();
    check("lvl_irq", 32'(irq[7]), 32'd1);
    bus_wr(3'd0, 4'h1, 32'h4);
    check("lvl_w1c", 32'(irq[7]), 32'd1);
    src[2] = 1'b0;
    tick(); tick();
    check("lvl_hold2", 32'(irq[7]), 32'd1);
    tick();
    check("lvl_drop", 32'(irq[7]), 32'd0);

    // Collision: W1C lands on the same edge as a new rise
    bus_wr(3'd1, 4'h1, 32'h1);
    bus_wr(3'd2, 4'h1, 32'h1);
    bus_wr(3'd0, 4'h1, 32'hFF);
    src[0] = 1'b1;
    tick(); tick();
    valid = 1'b1; addr = 32'h0; wstrb = 4'h1; wdata = 32'h1;
    tick();
    valid = 1'b0; wstrb = '0;
    tick();
    bus(3'd0, 4'd0, 32'd0, d);
    check("collide", d, 32'h1);
    bus_wr(3'd0, 4'h1, 32'h1);
    src = '0;

    // Bus: valid held 4 cycles on STATUS
    bus_wr(3'd2, 4'h1, 32'h0);
    bus_wr(3'd1, 4'h1, 32'hFF);
    src = 8'h5A;
    repeat (3) tick();
    valid = 1'b1; addr = 32'h0C; wstrb = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bus_ready", 32'(ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) check("bus_status", rdata, 32'h5A);
    end
    valid = 1'b0;
    tick();
    bus_wr(3'd1, 4'h1, 32'hFFFF_FFFF);
    bus(3'd1, 4'd0, 32'd0, d);
    check("bus_strb", d, 32'hFF);

    // Reset mid-transaction drops it; reset clears ready asynchronously
    valid = 1'b1; addr = 32'h0; wstrb = 4'd0;
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_drop_ready", 32'(ready), 32'd0);
    check("rst_drop_irq", irq, 32'd0);
    valid = 1'b0;
    src = '0;
    release_reset();
    tick();
    bus_wr(3'd1, 4'h1, 32'hFF);
    src = 8'h0F;
    repeat (3) tick();
    valid = 1'b1; addr = 32'h0C; wstrb = 4'd0;
    tick();
    check("async_pre", 32'(ready), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_ready", 32'(ready), 32'd0);
    check("async_rdata", rdata, 32'd0);
    check("async_irq", irq, 32'd0);
    valid = 1'b0;
    src = '0;
    @(posedge clk);
    release_reset();

    // Polarity option
    bus_wr(3'd4, 4'h1, 32'h2);
    bus_wr(3'd1, 4'h1, 32'h2);
    bus_wr(3'd2, 4'h1, 32'h0);
    repeat (3) tick();
    bus(3'd4, 4'd0, 32'd0, d);
`ifdef IRQ_CTRL_POLARITY_EN
    check("pol_irq", 32'(irq[6]), 32'd1);
    check("pol_read", d, 32'h2);
    bus_wr(3'd4, 4'h1, 32'h0);
`else
    check("pol_irq", 32'(irq[6]), 32'd0);
    check("pol_read", d, 32'h0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) src = src ^ (NSRC'(1) << $urandom_range(0, NSRC-1));
      if ($urandom_range(0, 2) == 0) begin
        ri  = 3'($urandom_range(0, 7));
        rws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        bus(ri, rws, $urandom, d);
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
